clkdiv_monitor: RTL and testbench

Receive-side checker for the /2, /4, /8 ripple clock-divider outputs. It samples the three divided clocks on every rising edge of the source clock and checks that the 3-bit phase word advances by exactly one step per edge. It reports lock status, counts phase errors, and emits a /8 frame marker. It sits downstream of the divider chip model, in the source-clock domain, ahead of any logic that trusts the divided clocks.

---
 rtl/clkdiv_mon_pkg.sv | 36 +++
 rtl/clkdiv_phase_sampler.sv | 66 ++++++
 rtl/clkdiv_monitor.sv | 152 +++++++++++++++
 tb/tb_clkdiv_monitor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_mon_pkg
// Purpose  : Shared types and helpers for the clock-divider phase monitor.
//            Holds the monitor state encoding, the 3-bit phase word type and
//            the expected-next-phase function.
// Revision : 1.0 - initial release
// ============================================================================
package clkdiv_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    // Phase word layout: {DIV8, DIV4, DIV2}
    typedef logic [2:0] phase_t;

    // Sample-valid count at which a prev/cur comparison is meaningful
    localparam logic [1:0] VLD_FULL = 2'd2;

    // Expected phase one source-clock edge after 'phase'.
    // dir = 1: ripple divider counts down; dir = 0: counts up. Wraps mod 8.
    function automatic phase_t next_phase(input phase_t phase, input logic dir);
        phase_t nxt;
        if (dir) begin
            nxt = phase - 3'd1;
        end else begin
            nxt = phase + 3'd1;
        end
        return nxt;
    endfunction

endpackage : clkdiv_mon_pkg
`default_nettype wire

// File: rtl/clkdiv_phase_sampler.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_phase_sampler
// Purpose  : Registers the divided-clock phase word on each enabled source
//            clock edge and keeps the previous sample so the parent can check
//            the step between them.
// Ports    : clk       - source clock
//            rst_n     - asynchronous active-low reset
//            en_n      - active-low sample enable (high clears valid count)
//            sample    - raw phase word {DIV8, DIV4, DIV2}
//            cur       - most recent registered sample
//            prev      - sample registered one enabled edge before cur
//            cmp_valid - both cur and prev hold real samples
// Revision : 1.0 - initial release
// ============================================================================
module clkdiv_phase_sampler
    import clkdiv_mon_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en_n,
    input  phase_t sample,
    output phase_t cur,
    output phase_t prev,
    output logic   cmp_valid
);

    phase_t     cur_q,  cur_d;
    phase_t     prev_q, prev_d;
    logic [1:0] vld_q,  vld_d;

    always_comb begin
        cur_d  = cur_q;
        prev_d = prev_q;
        vld_d  = vld_q;
        if (!en_n) begin
            cur_d  = sample;
            prev_d = cur_q;
            if (vld_q != VLD_FULL) begin
                vld_d = vld_q + 2'd1;
            end
        end else begin
            // Disabled: phase history is stale, so force a fresh two-sample
            // fill before the next comparison.
            vld_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q  <= 3'd0;
            prev_q <= 3'd0;
            vld_q  <= 2'd0;
        end else begin
            cur_q  <= cur_d;
            prev_q <= prev_d;
            vld_q  <= vld_d;
        end
    end

    assign cur       = cur_q;
    assign prev      = prev_q;
    assign cmp_valid = (vld_q == VLD_FULL);

endmodule : clkdiv_phase_sampler
`default_nettype wire

// File: rtl/clkdiv_monitor.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_monitor
// Purpose  : Receive-side checker for /2, /4, /8 ripple divider outputs.
//            Verifies the sampled phase word moves exactly one step per
//            source clock edge, tracks lock, counts phase errors and flags
//            the /8 frame boundary.
// Ports    : CLK       - source clock driving the divider
//            MR_       - asynchronous active-low master reset
//            EN_       - active-low synchronous monitor enable
//            DIV2/4/8  - divider outputs, phase bits 0/1/2
//            CLR_ERR   - synchronous clear of ERR_CNT
//            PHASE     - last sampled phase word {DIV8, DIV4, DIV2}
//            LOCK      - high while locked
//            ERR_PULSE - one-cycle pulse per bad step seen while locked
//            ERR_CNT   - saturating count of ERR_PULSE events
//            SYNC8     - one-cycle pulse when locked phase reaches 3'b000
// Revision : 1.0 - initial release
// ============================================================================
module clkdiv_monitor
    import clkdiv_mon_pkg::*;
#(
    parameter bit          DIR      = 1'b1,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             CLK,
    input  logic             MR_,
    input  logic             EN_,
    input  logic             DIV2,
    input  logic             DIV4,
    input  logic             DIV8,
    input  logic             CLR_ERR,
    output logic [2:0]       PHASE,
    output logic             LOCK,
    output logic             ERR_PULSE,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             SYNC8
);

    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    phase_t w_cur;
    phase_t w_prev;
    logic   w_cmp_valid;
    logic   w_good;
    logic   w_bad;
    logic [3:0] w_gc_inc;

    state_e           state_q,     state_d;
    logic [3:0]       gc_q,        gc_d;
    logic [ERR_W-1:0] err_cnt_q,   err_cnt_d;
    logic             err_pulse_q, err_pulse_d;
    logic             sync8_q,     sync8_d;
    logic             lock_q,      lock_d;

    clkdiv_phase_sampler u_sampler (
        .clk       (CLK),
        .rst_n     (MR_),
        .en_n      (EN_),
        .sample    ({DIV8, DIV4, DIV2}),
        .cur       (w_cur),
        .prev      (w_prev),
        .cmp_valid (w_cmp_valid)
    );

    assign w_good   = w_cmp_valid && (w_cur == next_phase(w_prev, DIR));
    assign w_bad    = w_cmp_valid && !w_good;
    assign w_gc_inc = gc_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        gc_d        = gc_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        sync8_d     = 1'b0;

        if (EN_) begin
            state_d = IDLE;
            gc_d    = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    gc_d    = 4'd0;
                end
                ACQUIRE: begin
                    // Misses while acquiring only restart the run; they are
                    // not counted as errors.
                    if (w_good) begin
                        gc_d = w_gc_inc;
                        if (w_gc_inc == LOCK_TGT) begin
                            state_d = LOCKED;
                        end
                    end else if (w_bad) begin
                        gc_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (w_bad) begin
                        err_pulse_d = 1'b1;
                        gc_d        = 4'd0;
                        state_d     = ACQUIRE;
                        if (err_cnt_q != ERR_MAX) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                    end else if (w_good && (w_cur == 3'd0)) begin
                        sync8_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    gc_d    = 4'd0;
                end
            endcase
        end

        // Clear wins over a same-edge increment; the pulse is unaffected.
        if (CLR_ERR) begin
            err_cnt_d = '0;
        end
    end

    assign lock_d = (state_d == LOCKED);

    always_ff @(posedge CLK or negedge MR_) begin
        if (!MR_) begin
            state_q     <= IDLE;
            gc_q        <= 4'd0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            sync8_q     <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gc_q        <= gc_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
            sync8_q     <= sync8_d;
            lock_q      <= lock_d;
        end
    end

    assign PHASE     = w_cur;
    assign LOCK      = lock_q;
    assign ERR_PULSE = err_pulse_q;
    assign ERR_CNT   = err_cnt_q;
    assign SYNC8     = sync8_q;

endmodule : clkdiv_monitor
`default_nettype wire

// File: tb/tb_clkdiv_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_clkdiv_monitor
// Purpose  : Directed self-checking bench for clkdiv_monitor. Three instances
//            share clock, reset, enable and clear: dut_a (down, ERR_W=8),
//            dut_b (down, ERR_W=2, same phase inputs as dut_a) and dut_c
//            (up-counting, fed its own incrementing phase word).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clkdiv_monitor;
    import clkdiv_mon_pkg::*;

    logic       clk     = 1'b0;
    logic       mr_n    = 1'b1;
    logic       en_n    = 1'b1;
    logic       clr_err = 1'b0;
    logic [2:0] pd      = 3'd0;
    logic [2:0] pu      = 3'd0;
    logic [2:0] last_pd = 3'd0;

    logic [2:0] a_phase, b_phase, c_phase;
    logic       a_lock, b_lock, c_lock;
    logic       a_errp, b_errp, c_errp;
    logic [7:0] a_cnt, c_cnt;
    logic [1:0] b_cnt;
    logic       a_sync8, b_sync8, c_sync8;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    clkdiv_monitor #(.DIR(1'b1), .LOCK_CNT(4), .ERR_W(8)) dut_a (
        .CLK(clk), .MR_(mr_n), .EN_(en_n),
        .DIV2(pd[0]), .DIV4(pd[1]), .DIV8(pd[2]), .CLR_ERR(clr_err),
        .PHASE(a_phase), .LOCK(a_lock), .ERR_PULSE(a_errp),
        .ERR_CNT(a_cnt), .SYNC8(a_sync8)
    );

    clkdiv_monitor #(.DIR(1'b1), .LOCK_CNT(4), .ERR_W(2)) dut_b (
        .CLK(clk), .MR_(mr_n), .EN_(en_n),
        .DIV2(pd[0]), .DIV4(pd[1]), .DIV8(pd[2]), .CLR_ERR(clr_err),
        .PHASE(b_phase), .LOCK(b_lock), .ERR_PULSE(b_errp),
        .ERR_CNT(b_cnt), .SYNC8(b_sync8)
    );

    clkdiv_monitor #(.DIR(1'b0), .LOCK_CNT(4), .ERR_W(8)) dut_c (
        .CLK(clk), .MR_(mr_n), .EN_(en_n),
        .DIV2(pu[0]), .DIV4(pu[1]), .DIV8(pu[2]), .CLR_ERR(clr_err),
        .PHASE(c_phase), .LOCK(c_lock), .ERR_PULSE(c_errp),
        .ERR_CNT(c_cnt), .SYNC8(c_sync8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive the down-phase word, clock one edge, sample 1 time unit later.
    // The up-phase word advances by one on every call.
    task automatic tick(input logic [2:0] d);
        pd      = d;
        last_pd = d;
        @(posedge clk);
        #1;
        pu = pu + 3'd1;
    endtask

    // Hand-computed ERR_CNT after each forced error in the saturation loop
    // (one error already counted before the loop; last error has CLR_ERR).
    int exp_cnt_a [6] = '{2, 3, 4, 5, 6, 0};
    int exp_cnt_b [6] = '{2, 3, 3, 3, 3, 0};

    initial begin
        logic [2:0] p;

        // ---------------- reset values ----------------
        #2 mr_n = 1'b0;
        #1;
        check("rst_phase",  a_phase, 0);
        check("rst_lock",   a_lock,  0);
        check("rst_errp",   a_errp,  0);
        check("rst_errcnt", a_cnt,   0);
        check("rst_sync8",  a_sync8, 0);
        repeat (2) @(posedge clk);
        #1 mr_n = 1'b1;

        // ---------------- lock acquisition (down) + up direction ----------------
        en_n = 1'b0;
        p    = 3'b000;
        pu   = 3'b110;
        for (int n = 1; n <= 18; n++) begin
            tick(p);
            check("t1_phase", a_phase, p);
            check("t1_lock",  a_lock,  (n >= 6));
            check("t1_sync8", a_sync8, (n == 10 || n == 18));
            check("t1_errp",  a_errp,  0);
            check("t6_lock",  c_lock,  (n >= 6));
            check("t6_sync8", c_sync8, (n == 12));
            p = next_phase(p, 1'b1);
        end
        check("t1_errcnt", a_cnt, 0);
        check("t6_errcnt", c_cnt, 0);
        check("t1_lock_b", b_lock, 1);

        // ---------------- error while locked ----------------
        tick(p);                        // 110
        p = next_phase(p, 1'b1);
        tick(p);                        // 101
        tick(p);                        // 101 repeated
        p = next_phase(p, 1'b1);
        tick(p);                        // compare of the repeat is bad here
        p = next_phase(p, 1'b1);
        check("t2_errp",   a_errp, 1);
        check("t2_lock",   a_lock, 0);
        check("t2_cnt_a",  a_cnt,  1);
        check("t2_cnt_b",  b_cnt,  1);
        tick(p);
        p = next_phase(p, 1'b1);
        check("t2_errp_1cyc", a_errp, 0);
        tick(p);
        p = next_phase(p, 1'b1);
        tick(p);
        p = next_phase(p, 1'b1);
        check("t2_lock_pre", a_lock, 0);
        tick(p);
        p = next_phase(p, 1'b1);
        check("t2_relock", a_lock, 1);

        // ---------------- disable while locked ----------------
        en_n = 1'b1;
        tick(p);
        check("t5_en_lock", a_lock, 0);
        check("t5_en_cnt",  a_cnt,  1);
        en_n = 1'b0;

        // ---------------- glitch during acquisition ----------------
        tick(3'b111);
        tick(3'b110);
        tick(3'b100);                   // skipped 101
        p = 3'b011;
        for (int m = 4; m <= 8; m++) begin
            tick(p);
            check("t3_lock", a_lock, (m == 8));
            check("t3_errp", a_errp, 0);
            check("t3_cnt",  a_cnt,  1);
            p = next_phase(p, 1'b1);
        end

        // ---------------- saturation and clear ----------------
        for (int k = 0; k < 6; k++) begin
            tick(last_pd);              // held phase
            clr_err = (k == 5);
            tick(p);
            p = next_phase(p, 1'b1);
            clr_err = 1'b0;
            check("t4_errp",  a_errp, 1);
            check("t4_lock",  a_lock, 0);
            check("t4_cnt_a", a_cnt,  exp_cnt_a[k]);
            check("t4_cnt_b", b_cnt,  exp_cnt_b[k]);
            repeat (3) begin
                tick(p);
                p = next_phase(p, 1'b1);
            end
        end
        tick(p);
        p = next_phase(p, 1'b1);
        check("t4_relock", a_lock, 1);
        check("t4_cnt_0",  a_cnt,  0);

        // ---------------- asynchronous reset mid-operation ----------------
        tick(last_pd);
        tick(p);
        p = next_phase(p, 1'b1);
        check("t5_cnt_pre", a_cnt, 1);
        repeat (4) begin
            tick(p);
            p = next_phase(p, 1'b1);
        end
        check("t5_lock_pre",  a_lock,  1);
        check("t5_phase_pre", a_phase, last_pd);
        #3 mr_n = 1'b0;
        #1;
        check("t5_mr_lock",  a_lock,  0);
        check("t5_mr_phase", a_phase, 0);
        check("t5_mr_cnt",   a_cnt,   0);
        check("t5_mr_cnt_b", b_cnt,   0);
        check("t5_mr_lockc", c_lock,  0);
        @(posedge clk);
        #1 mr_n = 1'b1;
        tick(3'b101);
        check("t5_restart_lock",  a_lock,  0);
        check("t5_restart_phase", a_phase, 3'b101);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_clkdiv_monitor
`default_nettype wire
